// File: rtl/dmem_responder.sv
// Data-memory responder for the 16-bit CPU data port: falling-edge single-ported array,
// tristate DD read drive, HOLD-gated preload, debug read, mailbox, store counter, range error.
module dmem_responder #(
    parameter int DEPTH     = 128,
    parameter int MBOX_ADDR = 0,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic          CK,
    input  logic          RST,
    input  logic [15:0]   DA,
    inout  wire  [15:0]   DD,
    input  logic          RW,
    input  logic          HOLD,
    input  logic          LD_VALID,
    output logic          LD_READY,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [15:0]   LD_DATA,
    input  logic [AW-1:0] DBG_ADDR,
    output logic [15:0]   DBG_DATA,
    output logic          MBOX_VALID,
    output logic [15:0]   MBOX_DATA,
    output logic [15:0]   WR_COUNT,
    output logic          ERR
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [15:0] MBOX_W  = 16'(MBOX_ADDR);

    logic [15:0] mem [DEPTH];

    logic [15:0] rdq_q, rdq_d;
    logic [15:0] dbg_q, dbg_d;
    logic        mbox_vld_q, mbox_vld_d;
    logic [15:0] mbox_dat_q, mbox_dat_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;

    logic cpu_en, in_range, dbg_ok, cpu_st, cpu_we, ld_fire, dd_oe;

    // Full 16-bit compare: upper DA bits never alias into the array.
    assign in_range = ({1'b0, DA} < DEPTH_W);
    assign dbg_ok   = (32'(DBG_ADDR) < 32'(DEPTH));
    assign cpu_en   = RST & ~HOLD;
    assign cpu_st   = cpu_en & ~RW;
    assign cpu_we   = cpu_st & in_range;
    assign LD_READY = HOLD & RST;
    assign ld_fire  = LD_VALID & LD_READY;

    // Enable is purely combinational so the bus releases in the same delta RW falls.
    assign dd_oe = RST & ~HOLD & RW;
    assign DD    = dd_oe ? rdq_q : 16'bz;

    always_ff @(negedge CK) begin
        if (cpu_we)
            mem[DA[AW-1:0]] <= DD;
        else if (ld_fire)
            mem[LD_ADDR] <= LD_DATA;
    end

    always_comb begin
        rdq_d      = rdq_q;
        dbg_d      = dbg_ok ? mem[DBG_ADDR] : 16'h0;
        mbox_vld_d = mbox_vld_q;
        mbox_dat_d = mbox_dat_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q;
        if (cpu_en && RW)
            rdq_d = in_range ? mem[DA[AW-1:0]] : 16'h0;
        if (cpu_en && !in_range)
            err_d = 1'b1;
        if (cpu_we && wcnt_q != 16'hFFFF)
            wcnt_d = wcnt_q + 16'd1;
        if (cpu_st && DA == MBOX_W) begin
            mbox_vld_d = 1'b1;
            mbox_dat_d = DD;
        end
    end

    always_ff @(negedge CK or negedge RST) begin
        if (!RST) begin
            rdq_q      <= '0;
            dbg_q      <= '0;
            mbox_vld_q <= 1'b0;
            mbox_dat_q <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            rdq_q      <= rdq_d;
            dbg_q      <= dbg_d;
            mbox_vld_q <= mbox_vld_d;
            mbox_dat_q <= mbox_dat_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
        end
    end

    assign DBG_DATA   = dbg_q;
    assign MBOX_VALID = mbox_vld_q;
    assign MBOX_DATA  = mbox_dat_q;
    assign WR_COUNT   = wcnt_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: preload, reads, mailbox, range errors, HOLD, async reset.
module tb_dmem_responder;

    logic        CK = 1'b1;
    logic        RST;
    logic [15:0] DA;
    wire  [15:0] DD;
    logic        RW, HOLD, LD_VALID, LD_READY;
    logic [6:0]  LD_ADDR, DBG_ADDR;
    logic [15:0] LD_DATA, DBG_DATA, MBOX_DATA, WR_COUNT;
    logic        MBOX_VALID, ERR;

    logic        tb_en;
    logic [15:0] tb_dd;
    assign DD = tb_en ? tb_dd : 16'bz;

    int n_chk = 0;
    int n_err = 0;

    always #5 CK = ~CK;

    dmem_responder dut (
        .CK(CK), .RST(RST), .DA(DA), .DD(DD), .RW(RW), .HOLD(HOLD),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA), .MBOX_VALID(MBOX_VALID),
        .MBOX_DATA(MBOX_DATA), .WR_COUNT(WR_COUNT), .ERR(ERR)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fall();
        @(negedge CK);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        DA = a; tb_dd = d; tb_en = 1'b1; RW = 1'b0;
        fall();
        RW = 1'b1; tb_en = 1'b0;
    endtask

    logic [6:0]  pl_a [4] = '{7'd0, 7'd1, 7'd2, 7'd3};
    logic [15:0] pl_d [4] = '{16'd5, 16'd15, 16'h2222, 16'h0333};

    initial begin
        RST = 1'b0; HOLD = 1'b1; RW = 1'b1; DA = '0; tb_en = 1'b0; tb_dd = '0;
        LD_VALID = 1'b0; LD_ADDR = '0; LD_DATA = '0; DBG_ADDR = '0;
        #1;
        chk("rst_wcnt", WR_COUNT, 16'h0);
        chk("rst_mbox_vld", {15'b0, MBOX_VALID}, 16'h0);
        chk("rst_err", {15'b0, ERR}, 16'h0);
        chk("rst_dbg", DBG_DATA, 16'h0);
        chk("rst_ld_ready", {15'b0, LD_READY}, 16'h0);
        #1 RST = 1'b1;
        #1;
        chk("hold_ld_ready", {15'b0, LD_READY}, 16'h1);

        // preload a few known words
        LD_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            LD_ADDR = pl_a[i]; LD_DATA = pl_d[i];
            fall();
        end
        LD_VALID = 1'b0;
        DBG_ADDR = 7'd0;
        fall();
        chk("pl_dbg0", DBG_DATA, 16'd5);
        chk("pl_wcnt", WR_COUNT, 16'h0);

        HOLD = 1'b0;
        #1;
        chk("run_ld_ready", {15'b0, LD_READY}, 16'h0);
        DA = 16'd1;
        fall();
        chk("rd_da1", DD, 16'd15);
        DA = 16'd0;
        fall();
        chk("rd_da0", DD, 16'd5);

        // mailbox store
        store(16'd0, 16'd4);
        chk("mbox_vld", {15'b0, MBOX_VALID}, 16'h1);
        chk("mbox_dat", MBOX_DATA, 16'd4);
        chk("mbox_wcnt", WR_COUNT, 16'd1);
        DBG_ADDR = 7'd0;
        fall();
        chk("mbox_dbg0", DBG_DATA, 16'd4);

        // top in-range word
        store(16'd127, 16'h7F7F);
        chk("top_err", {15'b0, ERR}, 16'h0);
        chk("top_wcnt", WR_COUNT, 16'd2);
        DA = 16'd127;
        fall();
        chk("top_rd", DD, 16'h7F7F);

        // out-of-range stores, including aliases of word 1 and the mailbox
        store(16'd200, 16'd7);
        chk("oor_err", {15'b0, ERR}, 16'h1);
        chk("oor_wcnt", WR_COUNT, 16'd2);
        store(16'd128, 16'h0BAD);
        store(16'h0081, 16'h0BAD);
        store(16'h8000, 16'h0077);
        chk("oor_mbox", MBOX_DATA, 16'd4);
        chk("oor_wcnt2", WR_COUNT, 16'd2);
        DA = 16'd200;
        fall();
        chk("oor_rd", DD, 16'h0);
        DBG_ADDR = 7'd1;
        fall();
        chk("oor_alias1", DBG_DATA, 16'd15);
        DBG_ADDR = 7'd0;
        fall();
        chk("oor_alias0", DBG_DATA, 16'd4);

        // HOLD blocks the CPU port; RDQ primed with 15 first
        DA = 16'd1;
        fall();
        chk("pre_hold_rd", DD, 16'd15);
        HOLD = 1'b1;
        store(16'd2, 16'd9);
        chk("hold_wcnt", WR_COUNT, 16'd2);
        DA = 16'd1; tb_dd = 16'h00F0; tb_en = 1'b1;
        fall();
        chk("hold_dd_float", DD, 16'h00F0);
        tb_en = 1'b0; HOLD = 1'b0;
        DBG_ADDR = 7'd2;
        fall();
        chk("hold_mem2", DBG_DATA, 16'h2222);
        chk("hold_err", {15'b0, ERR}, 16'h1);

        // write-then-read with same-edge debug collision
        DBG_ADDR = 7'd3;
        store(16'd3, 16'h1234);
        chk("wr_dbg_old", DBG_DATA, 16'h0333);
        chk("wr_wcnt", WR_COUNT, 16'd3);
        DA = 16'd3;
        fall();
        chk("wr_rd_new", DD, 16'h1234);

        // asynchronous reset mid-cycle
        DBG_ADDR = 7'd1;
        #2 RST = 1'b0;
        #1;
        chk("arst_mbox_vld", {15'b0, MBOX_VALID}, 16'h0);
        chk("arst_mbox_dat", MBOX_DATA, 16'h0);
        chk("arst_wcnt", WR_COUNT, 16'h0);
        chk("arst_err", {15'b0, ERR}, 16'h0);
        chk("arst_dbg", DBG_DATA, 16'h0);
        tb_dd = 16'h0C00; tb_en = 1'b1;
        #1;
        chk("arst_dd_float", DD, 16'h0C00);
        tb_en = 1'b0;
        fall();
        chk("arst_hold_dbg", DBG_DATA, 16'h0);
        #2 RST = 1'b1;
        fall();
        chk("rel_dbg1", DBG_DATA, 16'd15);
        chk("rel_rd3", DD, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 16-bit CPU's data port (DA/DD/RW). It serves CPU loads and stores from a single-ported 16-bit array, driving the shared bidirectional DD bus on reads and committing writes from it. A HOLD-gated preload port fills the array before a run. A debug read port, a mailbox-write detector, a store counter and a sticky range-error flag let the bench check results without peeking inside the array.

## Interface
- DEPTH, 128: number of 16-bit words; valid addresses are 0..DEPTH-1.
- MBOX_ADDR, 0: word address whose CPU store raises the mailbox.

- CK  in  1  clock; all storage updates on the falling edge.
- RST  in  1  asynchronous, active-low reset.
- DA  in  16  CPU data address.
- DD  inout  16  CPU data bus; driven by this block only while RW=1, HOLD=0 and RST=1, otherwise high-Z.
- RW  in  1  1 = CPU read (idle state), 0 = CPU write.
- HOLD  in  1  1 = CPU port ignored and preload enabled.
- LD_VALID  in  1  preload request.
- LD_READY  out  1  preload accept; combinational, equals HOLD & RST.
- LD_ADDR  in  7  preload word address.
- LD_DATA  in  16  preload data.
- DBG_ADDR  in  7  debug read address.
- DBG_DATA  out  16  registered debug read data.
- MBOX_VALID  out  1  sticky; set by a CPU store to MBOX_ADDR.
- MBOX_DATA  out  16  data of the most recent CPU store to MBOX_ADDR.
- WR_COUNT  out  16  committed CPU stores; saturates at 0xFFFF.
- ERR  out  1  sticky; set by a CPU access with DA >= DEPTH.

## Operation
- RW=1 means read. The CPU holds RW=1 whenever it is not storing, so every falling edge with RW=0 and HOLD=0 is a store.
- CPU read (HOLD=0, RW=1):
  - At each falling edge the read register RDQ loads mem[DA], or 0 if DA >= DEPTH.
  - DD = RDQ while the drive condition holds.
- CPU write (HOLD=0, RW=0):
  - If DA < DEPTH, mem[DA] = DD and WR_COUNT increments (saturating).
  - If DA = MBOX_ADDR, MBOX_VALID is set to 1 and MBOX_DATA is loaded with DD.
  - If DA >= DEPTH, no write and no count; ERR is set.
- Preload: a transfer occurs at a falling edge when LD_VALID & LD_READY; then mem[LD_ADDR] = LD_DATA. Preload does not affect WR_COUNT, MBOX or ERR.
- HOLD=1: CPU reads and writes are ignored, ERR is not updated, RDQ holds, and DD is high-Z.
- Debug: at every falling edge DBG_DATA loads mem[DBG_ADDR], or 0 if DBG_ADDR >= DEPTH, independent of HOLD.
- Upper DA bits: DA is compared in full 16 bits against DEPTH; there is no aliasing.

## Timing
- Reset (RST=0) takes effect immediately, with no clock edge needed:
  - RDQ = 0, DBG_DATA = 0, MBOX_VALID = 0, MBOX_DATA = 0, WR_COUNT = 0, ERR = 0.
  - LD_READY = 0 and DD is high-Z.
  - Array contents are not cleared.
- Reset released mid-cycle: the first falling edge after RST returns high operates normally.
- Read latency: DA presented at a rising edge gives valid data on DD from the following falling edge, so it is sampleable at the next rising edge (half a cycle).
- DD drive enable is combinational on RW, HOLD and RST. It turns off in the same delta as RW falls, so there is no bus contention on a store.
- Same-edge collisions resolve to old data:
  - A debug read of an address written at the same edge returns the old data.
  - A CPU read never coincides with a CPU write, because RW selects one.
- Read-after-write: a store at edge n is visible to a read sampled at edge n+1 or later.
- Reset asserted during a preload transfer: the transfer is dropped if RST is low at the falling edge.

## Test plan
- Preload, then read:
  - Stimulus: HOLD=1; preload mem[0]=5 and mem[1]=15; HOLD=0; CPU RW=1, DA=1.
  - Required: DD=15 after the next falling edge; LD_READY was 1 only while HOLD=1.
- Mailbox store:
  - Stimulus: CPU RW=0, DA=0, DD=4 for one cycle.
  - Required: MBOX_VALID=1, MBOX_DATA=4, WR_COUNT=1; a later DBG_ADDR=0 gives DBG_DATA=4.
- Out-of-range access:
  - Stimulus: store DA=200, DD=7; then read DA=200.
  - Required: ERR=1, WR_COUNT unchanged, DD=0 on the read, no array word changed.
- HOLD blocks the CPU:
  - Stimulus: HOLD=1 with RW=0, DA=2, DD=9.
  - Required: mem[2] unchanged, WR_COUNT unchanged, DD high-Z.
- Asynchronous reset:
  - Stimulus: after the scenarios above, pull RST low between clock edges.
  - Required: MBOX_VALID, MBOX_DATA, WR_COUNT, ERR and DBG_DATA read 0 immediately and DD is high-Z; after release, DBG_ADDR=1 returns 15.
- Write-then-read:
  - Stimulus: store DA=3, DD=0x1234; read DA=3 in the next cycle.
  - Required: DD=0x1234; a DBG_ADDR=3 read on the store edge returns the old value.
